// File: rtl/radix16_ntt_loader_if.sv
// Stream bundle for the radix-16 NTT loader: one beat-wide input stream,
// one block-wide output stream and the sticky framing flag.
interface radix16_ntt_loader_if #(
    parameter int N = 17
);
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      in_data;
    logic [N-1:0]      in_tf;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [16*N-1:0]   out_a;
    logic [15*N-1:0]   out_tf;
    logic              frame_err;

    // Loader side
    modport slave (
        input  in_valid, in_data, in_tf, in_last, out_ready,
        output in_ready, out_valid, out_a, out_tf, frame_err
    );

    // Producer / consumer side
    modport master (
        output in_valid, in_data, in_tf, in_last, out_ready,
        input  in_ready, out_valid, out_a, out_tf, frame_err
    );
endinterface

// File: rtl/radix16_ntt_loader.sv
// Ping-pong block assembler feeding the radix-16 DIT NTT core; reduces each
// coefficient into [0,Q). Define RADIX16_LOADER_BITREV_EN for bit-reversed slots.
module radix16_ntt_loader #(
    parameter int N = 17,
    parameter int Q = 65537
) (
    input  logic                  clk,
    input  logic                  rst_n,
    radix16_ntt_loader_if.slave   bus
);
    localparam logic [N-1:0] Q_N = N'(Q);

    logic [3:0]   wr_cnt_q, wr_cnt_d;
    logic         wr_bank_q, wr_bank_d;
    logic         rd_bank_q, rd_bank_d;
    logic [1:0]   full_q, full_d;
    logic         frame_err_q, frame_err_d;

    logic         in_ready_w;
    logic         out_valid_w;
    logic         accept;
    logic         consume;
    logic [3:0]   slot;
    logic [N-1:0] coef_red;

    wire [16*N-1:0] out_a_w;
    wire [15*N-1:0] out_tf_w;

    function automatic logic [3:0] slot_of(input logic [3:0] k);
`ifdef RADIX16_LOADER_BITREV_EN
        return {k[0], k[1], k[2], k[3]};
`else
        return k;
`endif
    endfunction

    // Ready depends only on registered bank state, never on out_ready.
    assign in_ready_w  = ~full_q[wr_bank_q];
    assign out_valid_w = full_q[rd_bank_q];
    assign accept      = bus.in_valid & in_ready_w;
    assign consume     = out_valid_w & bus.out_ready;
    assign slot        = slot_of(wr_cnt_q);

    // Q > 2^(N-1), so a single conditional subtract lands in [0,Q).
    assign coef_red = (bus.in_data >= Q_N) ? (bus.in_data - Q_N) : bus.in_data;

    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        frame_err_d = frame_err_q;

        if (accept) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
            if (bus.in_last != (wr_cnt_q == 4'd15)) begin
                frame_err_d = 1'b1;
            end
            if (wr_cnt_q == 4'd15) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        // A fill can only target an empty bank and a consume a full one,
        // so both updates may land on the same edge without conflict.
        if (consume) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q    <= 4'd0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= 2'b00;
            frame_err_q <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            frame_err_q <= frame_err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_slot
            logic [N-1:0] coef_q [0:1];
            logic [N-1:0] coef_d [0:1];
            logic         hit;

            assign hit = accept && (slot == 4'(gi));

            always_comb begin
                coef_d[0] = coef_q[0];
                coef_d[1] = coef_q[1];
                if (hit) begin
                    coef_d[wr_bank_q] = coef_red;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    coef_q[0] <= '0;
                    coef_q[1] <= '0;
                end else begin
                    coef_q[0] <= coef_d[0];
                    coef_q[1] <= coef_d[1];
                end
            end

            assign out_a_w[gi*N +: N] = coef_q[rd_bank_q];

            // Slot 0 carries no twiddle into the core.
            if (gi > 0) begin : g_tf
                logic [N-1:0] tf_q [0:1];
                logic [N-1:0] tf_d [0:1];

                always_comb begin
                    tf_d[0] = tf_q[0];
                    tf_d[1] = tf_q[1];
                    if (hit) begin
                        tf_d[wr_bank_q] = bus.in_tf;
                    end
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        tf_q[0] <= '0;
                        tf_q[1] <= '0;
                    end else begin
                        tf_q[0] <= tf_d[0];
                        tf_q[1] <= tf_d[1];
                    end
                end

                assign out_tf_w[(gi-1)*N +: N] = tf_q[rd_bank_q];
            end
        end
    endgenerate

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_a     = out_a_w;
    assign bus.out_tf    = out_tf_w;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_radix16_ntt_loader.sv
// Self-checking bench for radix16_ntt_loader: directed scenarios plus random
// traffic, checked against a two-deep block FIFO reference model.
module tb_radix16_ntt_loader;
    localparam int N  = 17;
    localparam int Q  = 65537;
    localparam int AW = 16 * N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    radix16_ntt_loader_if #(.N(N)) bus ();

    radix16_ntt_loader #(.N(N), .Q(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [16*N-1:0] a;
        logic [15*N-1:0] tf;
    } blk_t;

    blk_t         blk_q[$];
    logic [N-1:0] part_a  [16];
    logic [N-1:0] part_tf [16];
    int           beat_cnt;
    bit           err_exp;
    int           blocks_out;
    int           tests;
    int           fails;

    function automatic logic [3:0] slot_of(input int k);
        logic [3:0] kk;
        logic [3:0] r;
        kk = 4'(k);
        r  = '0;
`ifdef RADIX16_LOADER_BITREV_EN
        for (int i = 0; i < 4; i++) r[3-i] = kk[i];
`else
        r = kk;
`endif
        return r;
    endfunction

    task automatic model_reset();
        blk_q.delete();
        beat_cnt = 0;
        err_exp  = 1'b0;
    endtask

    task automatic model_accept(input logic [N-1:0] d, input logic [N-1:0] t, input logic l);
        int         dv;
        logic [3:0] s;
        blk_t       b;
        dv = int'(d);
        s  = slot_of(beat_cnt);
        part_a[s] = N'((dv >= Q) ? dv - Q : dv);
        if (s != 4'd0) part_tf[s] = t;
        if (l != (beat_cnt == 15)) err_exp = 1'b1;
        if (beat_cnt == 15) begin
            for (int k = 0; k < 16; k++) b.a[k*N +: N] = part_a[k];
            for (int k = 1; k < 16; k++) b.tf[(k-1)*N +: N] = part_tf[k];
            blk_q.push_back(b);
            beat_cnt = 0;
        end else begin
            beat_cnt++;
        end
    endtask

    task automatic model_consume();
        blk_t b;
        b = blk_q.pop_front();
        $display("[TB] block %0d consumed a0=%0d a15=%0d tf1=%0d", blocks_out,
                 b.a[0 +: N], b.a[15*N +: N], b.tf[0 +: N]);
        blocks_out++;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk_bit("out_valid", bus.out_valid, blk_q.size() > 0);
        chk_bit("in_ready", bus.in_ready, blk_q.size() < 2);
        chk_bit("frame_err", bus.frame_err, err_exp);
        if (blk_q.size() > 0) begin
            chk_vec("out_a", bus.out_a, blk_q[0].a);
            chk_vec("out_tf", {N'(0), bus.out_tf}, {N'(0), blk_q[0].tf});
        end
    endtask

    task automatic drive(input bit v, input logic [N-1:0] d, input logic [N-1:0] t, input bit l);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_tf    = t;
        bus.in_last  = l;
    endtask

    // Called 1 time unit after a rising edge; advances one clock and checks.
    task automatic tick(output bit acc);
        bit cons;
        #3;
        acc  = rst_n && bus.in_valid && (blk_q.size() < 2);
        cons = rst_n && bus.out_ready && (blk_q.size() > 0);
        @(posedge clk);
        #1;
        if (acc)  model_accept(bus.in_data, bus.in_tf, bus.in_last);
        if (cons) model_consume();
        if (rst_n) check_all();
    endtask

    initial begin
        bit              acc;
        int              n_acc;
        logic [AW-1:0]   va;
        logic [AW-1:0]   hold;
        tests = 0;
        fails = 0;
        blocks_out = 0;
        model_reset();
        drive(0, '0, '0, 0);
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_bit("rst_out_valid", bus.out_valid, 1'b0);
        chk_bit("rst_in_ready", bus.in_ready, 1'b1);
        chk_bit("rst_frame_err", bus.frame_err, 1'b0);
        chk_vec("rst_out_a", bus.out_a, '0);
        chk_vec("rst_out_tf", {N'(0), bus.out_tf}, '0);
        rst_n = 1'b1;
        tick(acc);

        // Natural-order block, out_ready held high
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            drive(1, N'(k), N'(100 + k), k == 15);
            tick(acc);
        end
        drive(0, '0, '0, 0);
        chk_bit("t1_valid", bus.out_valid, 1'b1);
        chk_vec("t1_a1", AW'(bus.out_a[1*N +: N]), AW'(slot_of(1)));
        chk_vec("t1_a3", AW'(bus.out_a[3*N +: N]), AW'(slot_of(3)));
        chk_vec("t1_a15", AW'(bus.out_a[15*N +: N]), AW'(15));
        chk_vec("t1_tf1", AW'(bus.out_tf[0 +: N]), AW'(100 + int'(slot_of(1))));
        tick(acc);
        tick(acc);

        // Reduction corner values
        bus.out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k == 0)      drive(1, N'(65536), N'($urandom), 0);
            else if (k == 1) drive(1, N'(65537), N'($urandom), 0);
            else if (k == 2) drive(1, N'(131071), N'($urandom), 0);
            else             drive(1, N'($urandom), N'($urandom), k == 15);
            tick(acc);
        end
        drive(0, '0, '0, 0);
        va = bus.out_a;
        chk_vec("red_65536", AW'(va[slot_of(0)*N +: N]), AW'(65536));
        chk_vec("red_65537", AW'(va[slot_of(1)*N +: N]), AW'(0));
        chk_vec("red_131071", AW'(va[slot_of(2)*N +: N]), AW'(65534));
        bus.out_ready = 1'b1;
        tick(acc);
        bus.out_ready = 1'b0;
        tick(acc);

        // Backpressure: 40 offered beats, only two blocks fit
        n_acc = 0;
        hold  = '0;
        for (int i = 0; i < 40; i++) begin
            drive(1, N'($urandom), N'($urandom), beat_cnt == 15);
            tick(acc);
            if (acc) n_acc++;
            if (i == 15) hold = bus.out_a;
        end
        drive(0, '0, '0, 0);
        chk_int("bp_accepted", n_acc, 32);
        chk_bit("bp_in_ready_low", bus.in_ready, 1'b0);
        chk_vec("bp_block0_held", bus.out_a, hold);
        bus.out_ready = 1'b1;
        tick(acc);
        bus.out_ready = 1'b0;
        chk_bit("bp_reopen", bus.in_ready, 1'b1);
        chk_bit("bp_block1_valid", bus.out_valid, 1'b1);
        tick(acc);
        bus.out_ready = 1'b1;
        tick(acc);
        tick(acc);

        // Framing error on beat 7
        bus.out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            drive(1, N'($urandom), N'($urandom), (k == 7) || (k == 15));
            tick(acc);
            if (k == 7) chk_bit("frame_b7", bus.frame_err, 1'b1);
        end
        drive(0, '0, '0, 0);
        chk_bit("frame_blk_valid", bus.out_valid, 1'b1);
        chk_bit("frame_sticky", bus.frame_err, 1'b1);
        bus.out_ready = 1'b1;
        tick(acc);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, N'($urandom), N'($urandom), beat_cnt == 15);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick(acc);
        end

        // Drain, then build a held block plus a 10-beat partial block
        drive(0, '0, '0, 0);
        bus.out_ready = 1'b1;
        repeat (3) tick(acc);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 40 && !(blk_q.size() == 1 && beat_cnt == 10); i++) begin
            drive(1, N'($urandom), N'($urandom), beat_cnt == 15);
            tick(acc);
        end
        drive(0, '0, '0, 0);
        chk_int("pre_rst_beats", beat_cnt, 10);

        // Asynchronous reset mid-block
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_bit("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk_bit("mid_rst_in_ready", bus.in_ready, 1'b1);
        chk_bit("mid_rst_frame_err", bus.frame_err, 1'b0);
        chk_vec("mid_rst_out_a", bus.out_a, '0);
        chk_vec("mid_rst_out_tf", {N'(0), bus.out_tf}, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(acc);
        chk_bit("post_rst_in_ready", bus.in_ready, 1'b1);
        chk_vec("post_rst_out_a", bus.out_a, '0);
        for (int k = 0; k < 16; k++) begin
            drive(1, N'($urandom), N'($urandom), k == 15);
            tick(acc);
        end
        drive(0, '0, '0, 0);
        chk_bit("post_rst_block", bus.out_valid, 1'b1);
        bus.out_ready = 1'b1;
        tick(acc);
        tick(acc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
